display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: CLK_DIV, 50000, clock cycles each digit is lit per scan slot (>=2).
REQ-002 Parameter: GAP_CYCLES, 16, cycles all anodes are off between digits, for anti-ghosting (>=1).
REQ-003 Port: clk  input  1  single system clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: load_valid  input  1  a new display value is offered on load_value.
REQ-006 Port: load_value  input  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 Port: load_ready  output  1  controller can accept a value; transfer occurs when load_valid and load_ready are both high at a rising edge.
REQ-008 Port: lzb_en  input  1  enables leading-zero blanking.
REQ-009 Port: blank_all  input  1  forces all anodes off while high; scanning continues.
REQ-010 Port: nibble  output  4  hex digit routed to the shared 7-segment decoder (active-low segments).
REQ-011 Port: an_n  output  4  digit anode enables, active-low, one-hot-low or all-high.
REQ-012 Port: digit_idx  output  2  index of the digit slot currently scheduled.

Function
REQ-013 Storage: disp_reg (16b, shown) and pend_reg (16b) with a pend_full flag.
REQ-014 The output load_ready SHALL equal ~pend_full and be purely registered-state driven, with no combinational path from load_valid.
REQ-015 Accept: load_value→pend_reg, pend_full←1 at that edge.
REQ-016 FSM states OFF, SHOW, GAP; reset state OFF.
REQ-017 OFF: an_n=4'hF, nibble=0, digit_idx=0; on pend_full, next edge copy pend_reg→disp_reg, clear pend_full, enter SHOW at digit 0, timer=0.
REQ-018 SHOW: timer counts 0..CLK_DIV-1; at CLK_DIV-1 enter GAP, timer=0.
REQ-019 GAP: an_n=4'hF; timer counts 0..GAP_CYCLES-1; at last cycle digit_idx increments mod 4 and state returns to SHOW.
REQ-020 Commit: only on the GAP→SHOW edge where digit_idx wraps 3→0; if pend_full, pend_reg→disp_reg and pend_full←0 at that edge (no tearing mid-scan).
REQ-021 nibble = disp_reg[4*digit_idx+3 : 4*digit_idx] in SHOW and GAP.
REQ-022 In SHOW, an_n[digit_idx] is low unless the slot is blanked; all other bits are high.
REQ-023 Slot blanked if blank_all=1, or lzb_en=1 and digit_idx>0 and all disp_reg digits at index >= digit_idx are zero; digit 0 never blanked by LZB.
REQ-024 blank_all/lzb_en are sampled combinationally into an_n; they do not affect timer, state, or commit.
REQ-025 Per-digit period = CLK_DIV+GAP_CYCLES cycles; full scan = 4x that.
REQ-026 Timer width = clog2(max(CLK_DIV,GAP_CYCLES)); no overflow or other wrap.
REQ-027 Nibble changes only on GAP→SHOW edges or OFF exit; never while an anode is low.

Reset
REQ-028 rst_n low asynchronously forces: state OFF, timer 0, digit_idx 0, disp_reg 0, pend_reg 0, pend_full 0, so load_ready=1, an_n=4'hF, nibble=0.
REQ-029 Reset mid-scan or with a pending value SHALL discard the pending value; no outputs glitch low on deassertion.
REQ-030 After rst_n rises, the block stays in OFF until the first accepted load.

Verification (CLK_DIV=4, GAP_CYCLES=2)
REQ-031 Reset, then load 16'h1234 -> load_ready 0 for 1 cycle; an_n=4'b1110, nibble=4 for 4 cycles, 4'hF for 2, then 4'b1101/nibble=3; full cycle 24 clk.
REQ-032 Display 16'h1234; load 16'hABCD while digit 1 shown -> load_ready stays 0; 16'hABCD appears only at the next digit-0 slot, then load_ready returns 1.
REQ-033 lzb_en=1, value 16'h0050 -> digits 2,3 an_n stay high; digit 1 (5) and digit 0 (0) lit; value 16'h0000 -> only digit 0 lit.
REQ-034 blank_all pulsed high for 10 cycles mid-scan -> an_n=4'hF throughout; digit_idx/timer sequence identical to the unblanked run.
REQ-035 Assert rst_n low during GAP with pend_full=1 -> outputs reach reset values before the next edge; after release, no digit is lit until a new load.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit display scanner: one digit lit per slot with an all-off
// gap between slots, double-buffered value committed only at scan wrap.
module display_scan_ctrl #(
    parameter int CLK_DIV    = 50000,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_value,
    output logic        load_ready,
    input  logic        lzb_en,
    input  logic        blank_all,
    output logic [3:0]  nibble,
    output logic [3:0]  an_n,
    output logic [1:0]  digit_idx
);

    localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [TW-1:0] SHOW_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_digit_idx;
    logic [15:0]   r_disp;
    logic [15:0]   r_pend;
    logic          r_pend_full;

    logic          w_accept;
    logic          w_commit;
    logic          w_blank;
    logic [3:0]    w_upper_zero;
    logic [3:0]    w_nib [4];
    logic [3:0]    w_onehot_n [4];

    // Per-slot digit value, one-hot-low anode pattern and "this digit and all
    // more-significant digits are zero" flag used by leading-zero blanking.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign w_nib[gi]        = r_disp[4*gi +: 4];
            assign w_onehot_n[gi]   = ~(4'b0001 << gi);
            assign w_upper_zero[gi] = (r_disp[15:4*gi] == '0);
        end
    endgenerate

    assign w_accept = load_valid & ~r_pend_full;
    assign w_commit = r_pend_full &
                      ((r_state == ST_OFF) ||
                       ((r_state == ST_GAP) && (r_timer == GAP_LAST) && (r_digit_idx == 2'd3)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_OFF;
            r_timer     <= '0;
            r_digit_idx <= 2'd0;
            r_disp      <= 16'h0000;
            r_pend      <= 16'h0000;
            r_pend_full <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    if (r_pend_full) begin
                        r_state     <= ST_SHOW;
                        r_timer     <= '0;
                        r_digit_idx <= 2'd0;
                    end
                end
                ST_SHOW: begin
                    if (r_timer == SHOW_LAST) begin
                        r_state <= ST_GAP;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_timer == GAP_LAST) begin
                        r_state     <= ST_SHOW;
                        r_timer     <= '0;
                        r_digit_idx <= r_digit_idx + 2'd1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_timer <= '0;
                end
            endcase

            if (w_commit) begin
                r_disp <= r_pend;
            end

            // Accept and commit are mutually exclusive: accept needs an empty buffer.
            if (w_accept) begin
                r_pend      <= load_value;
                r_pend_full <= 1'b1;
            end else if (w_commit) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    assign w_blank = blank_all |
                     (lzb_en & (r_digit_idx != 2'd0) & w_upper_zero[r_digit_idx]);

    assign load_ready = ~r_pend_full;
    assign digit_idx  = r_digit_idx;
    assign nibble     = (r_state == ST_OFF) ? 4'h0 : w_nib[r_digit_idx];
    assign an_n       = ((r_state == ST_SHOW) && !w_blank) ? w_onehot_n[r_digit_idx] : 4'hF;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with CLK_DIV=4, GAP_CYCLES=2,
// compared cycle by cycle against a scan-position reference model.
module tb_display_scan_ctrl;

    localparam int CD  = 4;
    localparam int GC  = 2;
    localparam int PER = CD + GC;
    localparam int SCAN = 4 * PER;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_value;
    logic        load_ready;
    logic        lzb_en;
    logic        blank_all;
    logic [3:0]  nibble;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl #(.CLK_DIV(CD), .GAP_CYCLES(GC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .lzb_en     (lzb_en),
        .blank_all  (blank_all),
        .nibble     (nibble),
        .an_n       (an_n),
        .digit_idx  (digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position within a 24-cycle scan once the display is running.
    logic        m_on;
    int          m_pos;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on   <= 1'b0;
            m_pos  <= 0;
            m_disp <= 16'h0;
            m_pend <= 16'h0;
            m_full <= 1'b0;
        end else begin
            if (!m_on) begin
                if (m_full) begin
                    m_disp <= m_pend;
                    m_full <= 1'b0;
                    m_on   <= 1'b1;
                    m_pos  <= 0;
                end
            end else begin
                m_pos <= (m_pos == SCAN - 1) ? 0 : m_pos + 1;
                if (m_pos == SCAN - 1 && m_full) begin
                    m_disp <= m_pend;
                    m_full <= 1'b0;
                end
            end
            if (load_valid && !m_full) begin
                m_pend <= load_value;
                m_full <= 1'b1;
            end
        end
    end

    function automatic logic [10:0] exp_vec();
        int d;
        logic [15:0] sh;
        logic show, blank;
        logic [3:0] nib, an;
        d     = m_on ? m_pos / PER : 0;
        show  = m_on && ((m_pos % PER) < CD);
        sh    = m_disp >> (4 * d);
        nib   = m_on ? sh[3:0] : 4'h0;
        blank = blank_all || (lzb_en && d > 0 && sh == 16'h0);
        an    = (show && !blank) ? ~(4'b0001 << d) : 4'hF;
        return {!m_full, an, nib, 2'(d)};
    endfunction

    logic [10:0] obs;
    assign obs = {load_ready, an_n, nibble, digit_idx};

    localparam logic [10:0] RESET_VEC = {1'b1, 4'hF, 4'h0, 2'd0};

    task automatic drive(input logic lv, input logic [15:0] val, input logic lz, input logic bl);
        load_valid = lv;
        load_value = val;
        lzb_en     = lz;
        blank_all  = bl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", obs, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== RESET_VEC) begin
                errors++;
                $display("FAIL idle_off cyc %0d got %h exp %h", c, obs, RESET_VEC);
            end
        end
    endtask

    task automatic test_basic();
        for (int c = 0; c < 2 * SCAN + 4; c++) begin
            @(negedge clk);
            drive(c == 0, 16'h1234, 1'b0, 1'b0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc %0d got %h exp %h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_pending();
        int budget = 0;
        while (!(m_on && m_pos / PER == 1 && (m_pos % PER) < CD) && budget < 100) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 1'b0, 1'b0);
            budget++;
        end
        checks++;
        if (budget >= 100) begin
            errors++;
            $display("FAIL pending_wait got timeout exp digit1");
        end
        for (int c = 0; c < 2 * SCAN; c++) begin
            @(negedge clk);
            drive(c == 0, 16'hABCD, 1'b0, 1'b0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL pending cyc %0d got %h exp %h", c, obs, exp_vec());
            end
        end
        checks++;
        if (m_disp !== 16'hABCD || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL pending_commit got ready %b exp 1", load_ready);
        end
    endtask

    task automatic test_lzb();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            for (int c = 0; c < 2 * SCAN + 2; c++) begin
                @(negedge clk);
                drive(c == 0, vals[v], 1'b1, 1'b0);
                #1;
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL lzb val %h cyc %0d got %h exp %h", vals[v], c, obs, exp_vec());
                end
            end
        end
    endtask

    task automatic test_blank();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            drive(c == 0, 16'h8F2E, 1'b0, (c >= 30 && c < 40) ? 1'b1 : 1'b0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL blank cyc %0d got %h exp %h", c, obs, exp_vec());
            end
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 1'b0, (c >= 7 && c < 17) ? 1'b1 : 1'b0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL blank_mid cyc %0d got %h exp %h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            drive(($urandom_range(0, 9) == 0), 16'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %h exp %h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int budget = 0;
        while (!(m_on && m_full && (m_pos % PER) >= CD) && budget < 100) begin
            @(negedge clk);
            drive(1'b1, 16'h5A5A, 1'b0, 1'b0);
            budget++;
        end
        checks++;
        if (budget >= 100) begin
            errors++;
            $display("FAIL reset_mid_wait got timeout exp gap_with_pending");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_mid_async got %h exp %h", obs, RESET_VEC);
        end
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            drive(1'b0, 16'h0, 1'b1, 1'b0);
            #1;
            checks++;
            if (obs !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d got %h exp %h", c, obs, RESET_VEC);
            end
        end
        for (int c = 0; c < SCAN; c++) begin
            @(negedge clk);
            drive(c == 0, 16'h0907, 1'b0, 1'b0);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_reload cyc %0d got %h exp %h", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pending();
        test_lzb();
        test_blank();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
